// File: rtl/sa_scan_ctrl.sv
// Scan-chain BIST controller: LFSR stimulus into a scan chain, capture pulses, MISR compaction of scan-out.
// Optional macro SA_SCAN_CTRL_SIG_CMP_EN adds a golden-signature input and a registered pass flag.
module sa_scan_ctrl #(
  parameter int          CHAIN_LEN    = 16,
  parameter int          NUM_PATTERNS = 8,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic        CP,
  input  logic        CDN,
  input  logic        start,
  input  logic        scan_so,
`ifdef SA_SCAN_CTRL_SIG_CMP_EN
  input  logic [15:0] golden,
  output logic        pass,
`endif
  output logic        scan_se,
  output logic        scan_si,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic [15:0] pat_cnt
);

  localparam int               CNT_W    = $clog2(CHAIN_LEN + 1);
  localparam logic [15:0]      SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [CNT_W-1:0] TC       = CNT_W'(CHAIN_LEN - 1);
  localparam logic [16:0]      NP       = 17'(NUM_PATTERNS);

  typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, FLUSH, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_nxt;
  logic [15:0]      misr_nxt;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic so);
    return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10] ^ so};
  endfunction

  assign lfsr_nxt = lfsr_step(lfsr);
  assign misr_nxt = misr_step(signature, scan_so);

  // The signature register is the MISR itself; it is cleared at start and frozen outside SHIFT/FLUSH.
  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      lfsr      <= SEED_EFF;
      scan_se   <= 1'b0;
      scan_si   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      signature <= 16'h0000;
      pat_cnt   <= 16'h0000;
`ifdef SA_SCAN_CTRL_SIG_CMP_EN
      pass      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            pat_cnt   <= 16'h0000;
            signature <= 16'h0000;
            lfsr      <= SEED_EFF;
            scan_se   <= 1'b1;
            scan_si   <= SEED_EFF[15];
            busy      <= 1'b1;
`ifdef SA_SCAN_CTRL_SIG_CMP_EN
            pass      <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          // Unload of the previous capture overlaps this load; the first load unloads nothing useful.
          lfsr <= lfsr_nxt;
          if (pat_cnt != 16'h0000) signature <= misr_nxt;
          if (bit_cnt == TC) begin
            bit_cnt <= '0;
            state   <= CAPTURE;
            scan_se <= 1'b0;
            scan_si <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            scan_si <= lfsr_nxt[15];
          end
        end
        CAPTURE: begin
          pat_cnt <= (pat_cnt == 16'hFFFF) ? pat_cnt : pat_cnt + 16'd1;
          scan_se <= 1'b1;
          if (({1'b0, pat_cnt} + 17'd1) < NP) begin
            state   <= SHIFT;
            scan_si <= lfsr[15];
          end else begin
            state   <= FLUSH;
            scan_si <= 1'b0;
          end
        end
        FLUSH: begin
          signature <= misr_nxt;
          if (bit_cnt == TC) begin
            bit_cnt <= '0;
            state   <= DONE;
            scan_se <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
`ifdef SA_SCAN_CTRL_SIG_CMP_EN
            pass    <= (misr_nxt == golden);
`endif
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_scan_ctrl.sv
// Bench for sa_scan_ctrl: three instances with behavioural scan chains, expected signatures queued at start.
module tb_sa_scan_ctrl;

  logic CP = 1'b0;
  logic CDN;
  always #5 CP = ~CP;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  logic start4, start8, start16;
  logic se4, si4, busy4, done4, so4;
  logic se8, si8, busy8, done8, so8;
  logic se16, si16, busy16, done16;
  logic [15:0] sig4, pc4, sig8, pc8, sig16, pc16;
`ifdef SA_SCAN_CTRL_SIG_CMP_EN
  logic [15:0] golden4, golden_zero;
  logic pass4, pass8, pass16;
  logic pass_at_done, pass_at_c1;
`endif

  logic [3:0]  ch4;
  logic [7:0]  ch8;
  logic [15:0] ch16;

  // Chain models: reset-to-1 flops; capture loads the inverted contents (stand-in for datapath D).
  always @(posedge CP or negedge CDN)
    if (!CDN) ch4 <= '1; else if (se4) ch4 <= {ch4[2:0], si4}; else ch4 <= ~ch4;
  always @(posedge CP or negedge CDN)
    if (!CDN) ch8 <= '1; else if (se8) ch8 <= {ch8[6:0], si8}; else ch8 <= ~ch8;
  always @(posedge CP or negedge CDN)
    if (!CDN) ch16 <= '1; else if (se16) ch16 <= {ch16[14:0], si16};
  assign so4 = ch4[3];
  assign so8 = ch8[7];

  sa_scan_ctrl #(.CHAIN_LEN(4), .NUM_PATTERNS(1), .SEED(16'hACE1)) u4 (
    .CP(CP), .CDN(CDN), .start(start4), .scan_so(so4),
`ifdef SA_SCAN_CTRL_SIG_CMP_EN
    .golden(golden4), .pass(pass4),
`endif
    .scan_se(se4), .scan_si(si4), .busy(busy4), .done(done4), .signature(sig4), .pat_cnt(pc4));

  sa_scan_ctrl #(.CHAIN_LEN(8), .NUM_PATTERNS(2), .SEED(16'hACE1)) u8 (
    .CP(CP), .CDN(CDN), .start(start8), .scan_so(so8),
`ifdef SA_SCAN_CTRL_SIG_CMP_EN
    .golden(golden_zero), .pass(pass8),
`endif
    .scan_se(se8), .scan_si(si8), .busy(busy8), .done(done8), .signature(sig8), .pat_cnt(pc8));

  sa_scan_ctrl #(.CHAIN_LEN(16), .NUM_PATTERNS(3), .SEED(16'hACE1)) u16 (
    .CP(CP), .CDN(CDN), .start(start16), .scan_so(1'b0),
`ifdef SA_SCAN_CTRL_SIG_CMP_EN
    .golden(golden_zero), .pass(pass16),
`endif
    .scan_se(se16), .scan_si(si16), .busy(busy16), .done(done16), .signature(sig16), .pat_cnt(pc16));

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Whole-run model: load L LFSR bits per pattern, capture inverts, compress every unload after the first.
  function automatic logic [15:0] model_sig(input int L, input int np);
    logic [15:0] lf = 16'hACE1;
    logic [15:0] m  = 16'h0000;
    logic [63:0] ch = '1;
    logic so;
    for (int p = 0; p < np; p++) begin
      for (int i = 0; i < L; i++) begin
        so = ch[L-1];
        if (p > 0) m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10] ^ so};
        ch = {ch[62:0], lf[15]};
        lf = lstep(lf);
      end
      ch = ~ch;
    end
    for (int i = 0; i < L; i++) begin
      so = ch[L-1];
      m  = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10] ^ so};
      ch = {ch[62:0], 1'b0};
    end
    return m;
  endfunction

  function automatic logic [15:0] pop_exp();
    if (exp_q.size() == 0) return 16'hDEAD;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    repeat (20) @(negedge CP);
    checks += 5;
    if (se4 !== 1'b0)       begin errors++; $display("FAIL reset_se: got %b expected 0", se4); end
    if (busy4 !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy4); end
    if (done4 !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done4); end
    if (sig4 !== 16'h0000)  begin errors++; $display("FAIL reset_sig: got %h expected 0000", sig4); end
    if (pc4 !== 16'h0000)   begin errors++; $display("FAIL reset_patcnt: got %h expected 0000", pc4); end
`ifdef SA_SCAN_CTRL_SIG_CMP_EN
    checks++;
    if (pass4 !== 1'b0)     begin errors++; $display("FAIL reset_pass: got %b expected 0", pass4); end
`endif
  endtask

  task automatic test_single_timing();
    logic e_se, e_busy, e_done;
    logic [15:0] e;
    exp_q.push_back(model_sig(4, 1));
    start4 = 1'b1;
    @(negedge CP); start4 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      e_se   = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
      e_busy = (c <= 9);
      e_done = (c == 10);
      checks += 3;
      if (se4 !== e_se)     begin errors++; $display("FAIL timing_se c%0d: got %b expected %b", c, se4, e_se); end
      if (busy4 !== e_busy) begin errors++; $display("FAIL timing_busy c%0d: got %b expected %b", c, busy4, e_busy); end
      if (done4 !== e_done) begin errors++; $display("FAIL timing_done c%0d: got %b expected %b", c, done4, e_done); end
      if (c == 10) begin
        e = pop_exp();
        checks += 2;
        if (sig4 !== e)       begin errors++; $display("FAIL timing_sig: got %h expected %h", sig4, e); end
        if (pc4 !== 16'd1)    begin errors++; $display("FAIL timing_patcnt: got %0d expected 1", pc4); end
      end
      @(negedge CP);
    end
  endtask

  task automatic run4(input bit abuse, output int nbusy, output int dcyc, output logic [15:0] sig);
    int cyc;
    bit got;
    start4 = 1'b1;
    @(negedge CP); start4 = 1'b0;
    cyc = 1; nbusy = 0; dcyc = -1; got = 1'b0; sig = 16'hxxxx;
    while (!got && cyc < 100) begin
`ifdef SA_SCAN_CTRL_SIG_CMP_EN
      if (cyc == 1) pass_at_c1 = pass4;
`endif
      if (busy4) nbusy++;
      if (done4) begin
        got = 1'b1; dcyc = cyc; sig = sig4;
`ifdef SA_SCAN_CTRL_SIG_CMP_EN
        pass_at_done = pass4;
`endif
      end
      start4 = (abuse && (cyc == 2 || done4)) ? 1'b1 : 1'b0;
      if (!got) begin @(negedge CP); cyc++; end
    end
    @(negedge CP); start4 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (busy4 !== 1'b0 || se4 !== 1'b0) begin
        errors++; $display("FAIL no_restart k%0d: busy %b se %b expected 0 0", k, busy4, se4);
      end
      @(negedge CP);
    end
  endtask

  task automatic check_run4(input string tag, input int nbusy, input int dcyc, input logic [15:0] sig);
    logic [15:0] e;
    e = pop_exp();
    checks += 3;
    if (dcyc !== 10)  begin errors++; $display("FAIL %s_done_cycle: got %0d expected 10", tag, dcyc); end
    if (nbusy !== 9)  begin errors++; $display("FAIL %s_busy_cycles: got %0d expected 9", tag, nbusy); end
    if (sig !== e)    begin errors++; $display("FAIL %s_sig: got %h expected %h", tag, sig, e); end
  endtask

  task automatic test_abuse_start();
    int nb, dc;
    logic [15:0] s;
    exp_q.push_back(model_sig(4, 1));
    run4(1'b1, nb, dc, s);
    check_run4("abuse", nb, dc, s);
  endtask

  task automatic test_midrun_reset();
    int nb, dc;
    logic [15:0] s;
    start4 = 1'b1;
    @(negedge CP); start4 = 1'b0;
    @(negedge CP); @(negedge CP);
    checks++;
    if (se4 !== 1'b1) begin errors++; $display("FAIL midrun_se_before: got %b expected 1", se4); end
    CDN = 1'b0;
    #1;
    checks += 5;
    if (se4 !== 1'b0)      begin errors++; $display("FAIL async_se: got %b expected 0", se4); end
    if (busy4 !== 1'b0)    begin errors++; $display("FAIL async_busy: got %b expected 0", busy4); end
    if (si4 !== 1'b0)      begin errors++; $display("FAIL async_si: got %b expected 0", si4); end
    if (sig4 !== 16'h0000) begin errors++; $display("FAIL async_sig: got %h expected 0000", sig4); end
    if (pc4 !== 16'h0000)  begin errors++; $display("FAIL async_patcnt: got %h expected 0000", pc4); end
    @(negedge CP); CDN = 1'b1;
    @(negedge CP);
    exp_q.push_back(model_sig(4, 1));
    run4(1'b0, nb, dc, s);
    check_run4("after_reset", nb, dc, s);
  endtask

  task automatic test_stream();
    logic [15:0] lf, exp_ch, e;
    int cyc, nb;
    bit got;
    exp_q.push_back(16'h0000);
    lf = 16'hACE1; exp_ch = 16'h0000; nb = 0;
    start16 = 1'b1;
    @(negedge CP); start16 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (si16 !== lf[15]) begin errors++; $display("FAIL stream_si bit%0d: got %b expected %b", c - 1, si16, lf[15]); end
      exp_ch = {exp_ch[14:0], lf[15]};
      lf = lstep(lf);
      if (busy16) nb++;
      @(negedge CP);
    end
    checks += 2;
    if (se16 !== 1'b0)   begin errors++; $display("FAIL stream_capture_se: got %b expected 0", se16); end
    if (ch16 !== exp_ch) begin errors++; $display("FAIL stream_chain: got %h expected %h", ch16, exp_ch); end
    cyc = 17; got = 1'b0;
    while (!got && cyc < 200) begin
      if (busy16) nb++;
      if (done16) got = 1'b1; else begin @(negedge CP); cyc++; end
    end
    e = pop_exp();
    checks += 4;
    if (!got)            begin errors++; $display("FAIL stream_done_timeout: got none expected done"); end
    if (sig16 !== e)     begin errors++; $display("FAIL zero_so_sig: got %h expected %h", sig16, e); end
    if (pc16 !== 16'd3)  begin errors++; $display("FAIL stream_patcnt: got %0d expected 3", pc16); end
    if (nb !== 67)       begin errors++; $display("FAIL stream_busy_cycles: got %0d expected 67", nb); end
    @(negedge CP);
  endtask

  task automatic test_signature();
    logic [15:0] e;
    int cyc, nb;
    bit got;
    exp_q.push_back(model_sig(8, 2));
    start8 = 1'b1;
    @(negedge CP); start8 = 1'b0;
    cyc = 1; nb = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      if (busy8) nb++;
      if (done8) got = 1'b1; else begin @(negedge CP); cyc++; end
    end
    e = pop_exp();
    checks += 4;
    if (!got)          begin errors++; $display("FAIL sig8_done_timeout: got none expected done"); end
    if (sig8 !== e)    begin errors++; $display("FAIL sig8: got %h expected %h", sig8, e); end
    if (pc8 !== 16'd2) begin errors++; $display("FAIL sig8_patcnt: got %0d expected 2", pc8); end
    if (nb !== 26)     begin errors++; $display("FAIL sig8_busy_cycles: got %0d expected 26", nb); end
    repeat (3) @(negedge CP);
    checks++;
    if (sig8 !== e)    begin errors++; $display("FAIL sig8_hold: got %h expected %h", sig8, e); end
  endtask

`ifdef SA_SCAN_CTRL_SIG_CMP_EN
  task automatic test_sig_cmp();
    int nb, dc;
    logic [15:0] s;
    golden4 = model_sig(4, 1);
    exp_q.push_back(golden4);
    run4(1'b0, nb, dc, s);
    check_run4("cmp_match", nb, dc, s);
    checks += 2;
    if (pass_at_done !== 1'b1) begin errors++; $display("FAIL pass_match_at_done: got %b expected 1", pass_at_done); end
    if (pass4 !== 1'b1)        begin errors++; $display("FAIL pass_match_hold: got %b expected 1", pass4); end
    golden4 = model_sig(4, 1) ^ 16'h0001;
    exp_q.push_back(model_sig(4, 1));
    run4(1'b0, nb, dc, s);
    check_run4("cmp_miss", nb, dc, s);
    checks += 2;
    if (pass_at_c1 !== 1'b0)   begin errors++; $display("FAIL pass_cleared_by_start: got %b expected 0", pass_at_c1); end
    if (pass_at_done !== 1'b0) begin errors++; $display("FAIL pass_miss: got %b expected 0", pass_at_done); end
  endtask
`endif

  initial begin
    CDN = 1'b0;
    start4 = 1'b0; start8 = 1'b0; start16 = 1'b0;
`ifdef SA_SCAN_CTRL_SIG_CMP_EN
    golden4 = 16'h0000; golden_zero = 16'h0000;
    pass_at_done = 1'b0; pass_at_c1 = 1'b0;
`endif
    repeat (2) @(negedge CP);
    CDN = 1'b1;
    test_reset();
    test_single_timing();
    test_abuse_start();
    test_midrun_reset();
    test_stream();
    test_signature();
`ifdef SA_SCAN_CTRL_SIG_CMP_EN
    test_sig_cmp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
